// File: rtl/ysyx_23060332_wbu_pkg.sv
// ysyx_23060332_wbu_pkg: shared widths, WBU state encoding and load funct3 codes
//   XLEN    - register data width
//   RADDR_W - register address width
package ysyx_23060332_wbu_pkg;
   localparam int XLEN    = 32;
   localparam int RADDR_W = 5;
   typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_WB} wbu_state_e;
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
endpackage

// File: rtl/ysyx_23060332_wbu_load_ext.sv
// ysyx_23060332_load_ext: byte/half lane select and sign/zero extension of a load word
//   rdata  in  aligned memory word
//   offset in  byte offset of the load address
//   funct3 in  load width/sign
//   data   out extended register value
module ysyx_23060332_load_ext
   import ysyx_23060332_wbu_pkg::*;
(
   input  logic [XLEN-1:0] rdata,
   input  logic [1:0]      offset,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] data
);
   logic [XLEN-1:0] lane;
   // bytes shifted past the top of the word come in as zero
   assign lane = rdata >> {offset, 3'b000};
   always_comb begin
      data = funct3 == F3_LB  ? {{24{lane[7]}}, lane[7:0]}
           : funct3 == F3_LBU ? {24'h0, lane[7:0]}
           : funct3 == F3_LH  ? {{16{lane[15]}}, lane[15:0]}
           : funct3 == F3_LHU ? {16'h0, lane[15:0]}
           : rdata;
   end
endmodule

// File: rtl/ysyx_23060332_wbu.sv
// ysyx_23060332_wbu: write-back unit, one register write and one commit pulse per instruction
//   in_*          EXU valid/ready handshake carrying rd, rd_wen, is_load, funct3, result
//   mem_*         aligned word read channel used by loads (AR then R)
//   waddr/wdata/reg_wen  register-file write port, active only in WB
//   commit_valid  one-cycle retire pulse
//   YSYX_23060332_WB_FWD_EN adds fwd_valid/fwd_rd/fwd_data mirroring the WB write
module ysyx_23060332_wbu
   import ysyx_23060332_wbu_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [RADDR_W-1:0] in_rd,
   input  logic               in_rd_wen,
   input  logic               in_is_load,
   input  logic [2:0]         in_funct3,
   input  logic [XLEN-1:0]    in_result,
   output logic [XLEN-1:0]    mem_araddr,
   output logic               mem_arvalid,
   input  logic               mem_arready,
   input  logic               mem_rvalid,
   input  logic [XLEN-1:0]    mem_rdata,
   output logic               mem_rready,
   output logic [RADDR_W-1:0] waddr,
   output logic [XLEN-1:0]    wdata,
   output logic               reg_wen,
   output logic               commit_valid
`ifdef YSYX_23060332_WB_FWD_EN
   ,
   output logic               fwd_valid,
   output logic [RADDR_W-1:0] fwd_rd,
   output logic [XLEN-1:0]    fwd_data
`endif
);
   wbu_state_e         state, state_n;
   logic [RADDR_W-1:0] rd_q;
   logic               rd_wen_q;
   logic [2:0]         f3_q;
   logic [XLEN-1:0]    result_q, wdata_q, ld_data;
   logic               wb;
   ysyx_23060332_load_ext u_ext (
      .rdata  (mem_rdata),
      .offset (result_q[1:0]),
      .funct3 (f3_q),
      .data   (ld_data)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         rd_q     <= '0;
         rd_wen_q <= 1'b0;
         f3_q     <= '0;
         result_q <= '0;
         wdata_q  <= '0;
      end else begin
         state <= state_n;
         if (state == S_IDLE && in_valid) begin
            rd_q     <= in_rd;
            rd_wen_q <= in_rd_wen;
            f3_q     <= in_funct3;
            result_q <= in_result;
            wdata_q  <= in_result;
         end
         if (state == S_R && mem_rvalid) wdata_q <= ld_data;
      end
   end
   always_comb begin
      state_n = state == S_IDLE ? (in_valid ? (in_is_load ? S_AR : S_WB) : S_IDLE)
              : state == S_AR   ? (mem_arready ? S_R : S_AR)
              : state == S_R    ? (mem_rvalid ? S_WB : S_R)
              : S_IDLE;
   end
   assign wb           = state == S_WB;
   assign in_ready     = state == S_IDLE;
   assign mem_arvalid  = state == S_AR;
   assign mem_rready   = state == S_R;
   assign mem_araddr   = {result_q[XLEN-1:2], 2'b00};
   assign waddr        = wb ? rd_q : '0;
   assign wdata        = wb ? wdata_q : '0;
   assign reg_wen      = wb && rd_wen_q && rd_q != '0;
   assign commit_valid = wb;
`ifdef YSYX_23060332_WB_FWD_EN
   assign fwd_valid = reg_wen;
   assign fwd_rd    = waddr;
   assign fwd_data  = wdata;
`endif
endmodule
